mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
// - Execute-stage multiply/divide unit holding the architectural HI/LO registers.
// - Consumes the decoder's start strobe and mult/div opcode once they reach E, plus the forwarded rs/rt operands.
// - Models multi-cycle mult/div latency with a busy counter. The hazard unit stalls D while busy or start is high.
// - Supplies hi/lo to the E-stage result mux for mfhi/mflo.
// PARAMETERS
// - MULT_CYCLES  5   busy cycles for mult/multu/madd/maddu/msub/msubu (>=1)
// - DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
// - clk      in   1   rising-edge clock
// - reset_n  in   1   synchronous, active-low reset
// - start    in   1   launch a timed op (mult/div/madd class)
// - op       in   4   opcode: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo,
//                     7 madd, 8 maddu, 9 msub, 10 msubu, 11-15 none
// - a        in   32  rs operand (dividend / multiplicand / mthi-mtlo data)
// - b        in   32  rt operand (divisor / multiplier)
// - busy     out  1   timed op in flight
// - hi       out  32  HI register (registered output)
// - lo       out  32  LO register (registered output)
// BEHAVIOUR
// - Reset: reset_n==0 at a rising edge -> hi=0, lo=0, busy=0, counter=0, pending result discarded.
//   Reset has priority over every other event.
// - Idle (busy=0), start=1, timed op sampled at edge k:
//   - compute result from a/b/op into internal hold regs; load counter with N (MULT_CYCLES or DIV_CYCLES).
//   - busy=1 during cycles k+1 .. k+N. Counter decrements each edge.
//   - On the edge where counter==1: write hold regs to hi/lo and clear busy.
//   - New hi/lo visible in cycle k+N+1, the same cycle busy first reads 0.
// - start=1 with a non-timed op (0, 5, 6, 11-15): no busy, no effect.
// - mthi/mtlo (op 5/6, start=0, busy=0): hi<=a or lo<=a at the next edge; busy stays 0; 1-cycle write latency.
// - While busy: start and mthi/mtlo are ignored; hi/lo hold until commit. Ops are never queued.
// - Arithmetic:
//   - mult: signed 32x32 -> 64, {hi,lo}=product. multu: unsigned.
//   - div: lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
//     0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. divu: unsigned.
//   - b==0 for div/divu: full DIV_CYCLES busy, then hi/lo unchanged (no commit).
// - madd/maddu/msub/msubu: {hi,lo} <= {hi,lo} +/- (a*b), signed/unsigned product, 64-bit wrap.
//   Uses the hi/lo value at the start edge.
// - Operands are sampled only at the start edge; a/b changes during busy have no effect.
// - The result is computed combinationally at the start edge; the counter only models latency.
// CONFIGURATION
// - MD_MADD_EN defined: ops 7-10 are timed ops (MULT_CYCLES) as above.
// - MD_MADD_EN undefined: ops 7-10 are treated as op 0. No busy, hi/lo unchanged, no accumulate logic synthesised.
// TESTING
// - mult a=0xFFFFFFFF b=2 -> busy=1 for exactly 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFFE.
//   multu with same operands -> hi=0x00000001 lo=0xFFFFFFFE.
// - div a=0xFFFFFFF9 (-7) b=2 -> busy 10 cycles, then lo=0xFFFFFFFD hi=0xFFFFFFFF.
//   div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000 hi=0.
// - hi=0xAA lo=0xBB, divu b=0 -> busy 10 cycles, hi=0xAA lo=0xBB afterward.
// - mthi a=0x1234 then mtlo a=0x5678 on consecutive cycles -> hi=0x1234 one cycle later, lo=0x5678 the next, busy stays 0.
//   start mult during busy -> ignored; hi/lo equal the first op's result only.
// - mult in flight, reset_n=0 at busy cycle 3 -> next cycle busy=0, hi=lo=0; no commit appears later.
// - MD_MADD_EN: hi=0 lo=5, madd a=3 b=4 -> after 5 cycles lo=17, hi=0.
//   msubu a=1 b=0x20 -> {hi,lo}=0xFFFFFFFF_FFFFFFF1.
//   Without macro: the same madd gives busy=0 and lo stays 5.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: execute-stage multiply/divide unit owning the HI/LO registers.
// The result of a timed op is computed combinationally when it is launched and parked in
// hold registers; a down-counter then models the multi-cycle latency before the commit.
// Optional feature macro: MD_MADD_EN enables madd/maddu/msub/msubu (ops 7-10).
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MULT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] CNT_DIV  = CW'(DIV_CYCLES);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hold_hi_q, hold_hi_d;
  logic [31:0]   hold_lo_q, hold_lo_d;
  logic          hold_vld_q, hold_vld_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  // Ops that occupy the unit for a counted latency.
  function automatic logic is_timed(input logic [3:0] o);
    logic r;
    case (o)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: r = 1'b1;
`ifdef MD_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Ops whose product is signed (everything else multiplies unsigned).
  function automatic logic is_signed_mul(input logic [3:0] o);
    logic r;
    case (o)
      OP_MULT, OP_MADD, OP_MSUB: r = 1'b1;
      default:                   r = 1'b0;
    endcase
    return r;
  endfunction

  // Two's-complement negate, shared by the divider sign fix-ups.
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return (~v) + 32'd1;
  endfunction

  logic [63:0] mul_a_s, mul_b_s, prod_s;
  logic        div_signed_s, a_neg_s, b_neg_s;
  logic [31:0] a_mag_s, b_mag_s, b_safe_s, uq_s, ur_s, quot_s, rem_s;
  logic [63:0] res_s;
  logic        res_vld_s;
  logic [CW-1:0] lat_s;

  // Operand extension and 64-bit product; the low 64 bits are exact for both signednesses.
  always_comb begin
    mul_a_s = 64'd0;
    mul_b_s = 64'd0;
    if (is_signed_mul(op)) begin
      mul_a_s = {{32{a[31]}}, a};
      mul_b_s = {{32{b[31]}}, b};
    end else begin
      mul_a_s = {32'd0, a};
      mul_b_s = {32'd0, b};
    end
    prod_s = mul_a_s * mul_b_s;
  end

  // Sign-magnitude divide: truncating quotient, remainder follows the dividend's sign.
  // Working on magnitudes keeps 0x80000000 / -1 well defined (quotient wraps to 0x80000000).
  always_comb begin
    div_signed_s = (op == OP_DIV);
    a_neg_s      = div_signed_s & a[31];
    b_neg_s      = div_signed_s & b[31];
    a_mag_s      = a_neg_s ? neg32(a) : a;
    b_mag_s      = b_neg_s ? neg32(b) : b;
    b_safe_s     = (b_mag_s == 32'd0) ? 32'd1 : b_mag_s;
    uq_s         = a_mag_s / b_safe_s;
    ur_s         = a_mag_s % b_safe_s;
    quot_s       = (a_neg_s ^ b_neg_s) ? neg32(uq_s) : uq_s;
    rem_s        = a_neg_s ? neg32(ur_s) : ur_s;
  end

  // Result, commit-enable and latency for the op presented at the launch edge.
  always_comb begin
    res_s     = {hi_q, lo_q};
    res_vld_s = 1'b1;
    lat_s     = CNT_MULT;
    case (op)
      OP_MULT, OP_MULTU: begin
        res_s = prod_s;
      end
      OP_DIV, OP_DIVU: begin
        res_s     = {rem_s, quot_s};
        res_vld_s = (b != 32'd0);
        lat_s     = CNT_DIV;
      end
`ifdef MD_MADD_EN
      OP_MADD, OP_MADDU: begin
        res_s = {hi_q, lo_q} + prod_s;
      end
      OP_MSUB, OP_MSUBU: begin
        res_s = {hi_q, lo_q} - prod_s;
      end
`endif
      default: begin
        res_s     = {hi_q, lo_q};
        res_vld_s = 1'b0;
      end
    endcase
  end

  // Next-state logic: launch, latency countdown, commit and the mthi/mtlo moves.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_hi_d  = hold_hi_q;
    hold_lo_d  = hold_lo_q;
    hold_vld_d = hold_vld_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start && is_timed(op)) begin
          state_d    = ST_BUSY;
          cnt_d      = lat_s;
          hold_hi_d  = res_s[63:32];
          hold_lo_d  = res_s[31:0];
          hold_vld_d = res_vld_s;
        end else if (!start && (op == OP_MTHI)) begin
          hi_d = a;
        end else if (!start && (op == OP_MTLO)) begin
          lo_d = a;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_q == CNT_ONE) begin
          state_d    = ST_IDLE;
          cnt_d      = CNT_ZERO;
          hold_vld_d = 1'b0;
          if (hold_vld_q) begin
            hi_d = hold_hi_q;
            lo_d = hold_lo_q;
          end else begin
            hi_d = hi_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        cnt_d      = CNT_ZERO;
        hold_vld_d = 1'b0;
      end
    endcase
  end

  // State and architectural registers; reset discards any pending result.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= CNT_ZERO;
      hold_hi_q  <= 32'd0;
      hold_lo_q  <= 32'd0;
      hold_vld_q <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_hi_q  <= hold_hi_d;
      hold_lo_q  <= hold_lo_d;
      hold_vld_q <= hold_vld_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy = (state_q == ST_BUSY);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed and randomized checks of mult_div_unit against a
// cycle-level behavioural model using plain 64-bit arithmetic.
module tb_mult_div_unit;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int errors;

  // model state
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  bit          p_commit;
  int          m_rem;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_timed(input logic [3:0] o);
`ifdef MD_MADD_EN
    return (o >= 4'd1 && o <= 4'd4) || (o >= 4'd7 && o <= 4'd10);
`else
    return (o >= 4'd1 && o <= 4'd4);
`endif
  endfunction

  // Apply one rising edge to the model using the inputs present at that edge.
  task automatic model_edge(input logic s, input logic [3:0] o, input logic [31:0] av,
                            input logic [31:0] bv, input logic rn);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub;
    logic [63:0]     acc, prod;
    sa = $signed(av);
    sb = $signed(bv);
    ua = av;
    ub = bv;
    if (!rn) begin
      m_hi = 32'd0; m_lo = 32'd0; m_rem = 0; p_commit = 1'b0;
    end else if (m_rem > 0) begin
      if (m_rem == 1 && p_commit) begin
        m_hi = p_hi; m_lo = p_lo;
      end
      m_rem--;
    end else if (s && model_timed(o)) begin
      acc = {m_hi, m_lo};
      p_commit = 1'b1;
      m_rem = (o == 4'd3 || o == 4'd4) ? 10 : 5;
      prod = (o == 4'd1 || o == 4'd7 || o == 4'd9) ? 64'(sa * sb) : 64'(ua * ub);
      case (o)
        4'd1, 4'd2: acc = prod;
        4'd3: if (bv == 32'd0) p_commit = 1'b0;
              else begin sq = sa / sb; sr = sa % sb; acc = {sr[31:0], sq[31:0]}; end
        4'd4: if (bv == 32'd0) p_commit = 1'b0;
              else begin acc = {32'(ua % ub), 32'(ua / ub)}; end
        4'd7, 4'd8: acc = acc + prod;
        default: acc = acc - prod;
      endcase
      p_hi = acc[63:32];
      p_lo = acc[31:0];
    end else if (!s && o == 4'd5) begin
      m_hi = av;
    end else if (!s && o == 4'd6) begin
      m_lo = av;
    end
  endtask

  // Drive inputs, take one clock edge, then compare the DUT with the model.
  task automatic step(input logic s, input logic [3:0] o, input logic [31:0] av,
                      input logic [31:0] bv, input logic rn);
    start = s; op = o; a = av; b = bv; reset_n = rn;
    @(posedge clk);
    model_edge(s, o, av, bv, rn);
    @(negedge clk);
    check("busy", {63'd0, busy}, {63'd0, (m_rem > 0)});
    check("hi", {32'd0, hi}, {32'd0, m_hi});
    check("lo", {32'd0, lo}, {32'd0, m_lo});
  endtask

  // Launch an op then idle until busy drops (bounded); returns busy-cycle count.
  task automatic run_op(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                        output int n);
    step(1'b1, o, av, bv, 1'b1);
    n = 0;
    while (busy && n < 40) begin
      n++;
      step(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    end
    if (n >= 40) check("busy_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    int n;
    logic [31:0] ra, rb;
    logic [3:0]  ro;
    checks = 0; errors = 0;
    m_hi = 32'd0; m_lo = 32'd0; p_hi = 32'd0; p_lo = 32'd0; p_commit = 1'b0; m_rem = 0;
    start = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0; reset_n = 1'b0;

    step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    check("rst_state", {31'd0, busy, hi, lo}, 64'd0);

    run_op(4'd1, 32'hFFFFFFFF, 32'd2, n);
    check("mult_lat", 64'(n), 64'd5);
    check("mult_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);
    run_op(4'd2, 32'hFFFFFFFF, 32'd2, n);
    check("multu_res", {hi, lo}, 64'h00000001_FFFFFFFE);
    run_op(4'd3, 32'hFFFFFFF9, 32'd2, n);
    check("div_lat", 64'(n), 64'd10);
    check("div_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, n);
    check("div_ovf", {hi, lo}, 64'h00000000_80000000);

    step(1'b0, 4'd5, 32'hAA, 32'd0, 1'b1);
    step(1'b0, 4'd6, 32'hBB, 32'd0, 1'b1);
    run_op(4'd4, 32'd1234, 32'd0, n);
    check("divz_lat", 64'(n), 64'd10);
    check("divz_res", {hi, lo}, 64'h000000AA_000000BB);

    step(1'b0, 4'd5, 32'h1234, 32'd0, 1'b1);
    check("mthi", {32'd0, hi}, 64'h1234);
    step(1'b0, 4'd6, 32'h5678, 32'd0, 1'b1);
    check("mtlo", {31'd0, busy, lo}, 64'h5678);

    step(1'b1, 4'd1, 32'd3, 32'd4, 1'b1);
    step(1'b1, 4'd1, 32'd7, 32'd7, 1'b1);
    step(1'b0, 4'd5, 32'hDEAD, 32'd0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    check("ignore_busy", {hi, lo}, 64'd12);

    step(1'b1, 4'd2, 32'h10, 32'h10, 1'b1);
    step(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    step(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    check("rst_mid", {31'd0, busy, hi, lo}, 64'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    check("no_late_commit", {hi, lo}, 64'd0);

    step(1'b0, 4'd5, 32'd0, 32'd0, 1'b1);
    step(1'b0, 4'd6, 32'd5, 32'd0, 1'b1);
    run_op(4'd7, 32'd3, 32'd4, n);
`ifdef MD_MADD_EN
    check("madd_lat", 64'(n), 64'd5);
    check("madd_res", {hi, lo}, 64'd17);
    run_op(4'd10, 32'd1, 32'h20, n);
    check("msubu_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
`else
    check("madd_off_lat", 64'(n), 64'd0);
    check("madd_off_res", {hi, lo}, 64'd5);
`endif

    for (int i = 0; i < 600; i++) begin
      ra = $urandom;
      rb = $urandom;
      ro = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFFFFFF;
        2: ra = 32'h80000000;
        default: ra = ra;
      endcase
      step(1'($urandom_range(0, 1)), ro, ra, rb, ($urandom_range(0, 63) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
